pulse_gen_test: RTL and testbench
=================================

// Module: pulse_gen_test
// PURPOSE
//   Periodic pulse generator. Divides the system clock and emits a registered pulse
//   train on clkout: WIDTH cycles high out of every PERIOD cycles.
//   Sits beside the clock tree as a test/strobe source for downstream sequencing logic.
//   Fully synchronous. No combinational path from any input to clkout.
// PARAMETERS
//   PERIOD  4                 pulse period in clk cycles; legal range >= 2
//   WIDTH   1                 high time in clk cycles; legal range 1 <= WIDTH < PERIOD
//   CNT_W   $clog2(PERIOD)    phase counter width; derived, do not override
// PORTS
//   clk     in   1  system clock; all state updates on the rising edge
//   nrst    in   1  reset; synchronous, active-low
//   clkout  out  1  registered pulse output
// BEHAVIOUR
//   - Reset: on a rising clk edge with nrst=0, cnt <= 0 and clkout <= 0.
//     Before the first clk edge, clkout is undefined; at least one edge under reset is required.
//   - Run: on each rising edge with nrst=1:
//       clkout <= (cnt < WIDTH)
//       cnt    <= (cnt == PERIOD-1) ? 0 : cnt+1
//   - Latency: the first edge after reset release drives clkout=1.
//     clkout then stays high for exactly WIDTH edges and low for PERIOD-WIDTH edges. Repeats indefinitely.
//   - Wrap-around: cnt rolls from PERIOD-1 to 0 with no dead cycle.
//     For non-power-of-2 PERIOD, cnt never takes values >= PERIOD.
//   - Reset mid-operation: nrst=0 at any phase forces clkout=0 and cnt=0 on that edge.
//     Release restarts the sequence from phase 0, identical to the first release.
//   - Reset has priority over counting on the same edge.
//   - Illegal parameters (PERIOD<2, WIDTH<1, or WIDTH>=PERIOD) stop elaboration
//     with $error in a generate-time check.
//   - The output is glitch-free because clkout is a flop output.
// STRUCTURE
//   - Package pulse_gen_pkg: PULSE_PERIOD_DEF=4, PULSE_WIDTH_DEF=1,
//     and a function pulse_cnt_w(period) returning max(1,$clog2(period)).
//   - Sub-module pulse_gen_counter #(PERIOD,CNT_W) (clk, nrst, cnt, wrap): a mod-PERIOD phase counter.
//     The top level holds only the parameter checks and the clkout compare register.
// TESTING
//   - Reset: nrst=0, 1 clk edge -> clkout=0; 5 more edges with nrst=0 -> clkout stays 0.
//   - Default params, release nrst, 50 rising edges:
//       clkout=1 after edges 1,5,9,...,49 and 0 after all others (13 pulses, each 1 cycle wide).
//   - PERIOD=5, WIDTH=2, 20 edges: pattern 1,1,0,0,0 repeated.
//       Check the high count is 8 and the low count is 12.
//   - Mid-run reset: default params, assert nrst=0 at edge 3 of a period, hold 1 edge.
//       -> clkout=0 on that edge; next pulse appears on the first edge after release.
//   - PERIOD=2, WIDTH=1: clkout toggles every edge (divide-by-2).
//       cnt never exceeds 1.
//   - Illegal WIDTH=4 with PERIOD=4: elaboration fails with $error.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// rtl/pulse_gen_pkg.sv - shared defaults and counter-width helper for the pulse generator
package pulse_gen_pkg;

    localparam int PULSE_PERIOD_DEF = 4;
    localparam int PULSE_WIDTH_DEF  = 1;

    // A period of 1 or 2 still needs a one-bit phase counter.
    function automatic int pulse_cnt_w(input int period);
        int w;
        w = $clog2(period);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pulse_gen_if.sv
// rtl/pulse_gen_if.sv - pulse train bundle seen by downstream sequencing logic
interface pulse_gen_if;

    logic clkout;

    modport master (output clkout);
    modport slave  (input  clkout);

endinterface

// File: rtl/pulse_gen_counter.sv
// rtl/pulse_gen_counter.sv - mod-PERIOD phase counter with a wrap flag
module pulse_gen_counter
    import pulse_gen_pkg::*;
#(
    parameter int PERIOD = PULSE_PERIOD_DEF,
    parameter int CNT_W  = pulse_cnt_w(PERIOD)
) (
    input  logic             clk,
    input  logic             nrst,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Explicit compare against PERIOD-1 keeps non-power-of-2 periods in range.
    always_comb begin
        wrap  = (cnt_q == LAST);
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pulse_gen_test.sv
// rtl/pulse_gen_test.sv - periodic pulse generator, WIDTH high out of every PERIOD clocks
module pulse_gen_test
    import pulse_gen_pkg::*;
#(
    parameter int PERIOD = PULSE_PERIOD_DEF,
    parameter int WIDTH  = PULSE_WIDTH_DEF,
    parameter int CNT_W  = pulse_cnt_w(PERIOD)
) (
    input  logic clk,
    input  logic nrst,
    output logic clkout
);

    if (PERIOD < 2) begin : g_bad_period
        $error("pulse_gen_test: PERIOD must be >= 2");
    end
    if (WIDTH < 1) begin : g_bad_width_lo
        $error("pulse_gen_test: WIDTH must be >= 1");
    end
    if (WIDTH >= PERIOD) begin : g_bad_width_hi
        $error("pulse_gen_test: WIDTH must be < PERIOD");
    end

    logic [CNT_W-1:0] cnt;
    logic             cnt_wrap_unused;
    logic             clkout_q;
    logic             clkout_d;

    pulse_gen_counter #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_counter (
        .clk  (clk),
        .nrst (nrst),
        .cnt  (cnt),
        .wrap (cnt_wrap_unused)
    );

    // Registering the compare keeps clkout glitch-free and input-isolated.
    always_comb begin
        clkout_d = (cnt < CNT_W'(WIDTH));
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            clkout_q <= 1'b0;
        end else begin
            clkout_q <= clkout_d;
        end
    end

    assign clkout = clkout_q;

endmodule

// File: tb/tb_pulse_gen_test.sv
// tb/tb_pulse_gen_test.sv - self-checking bench for pulse_gen_test across three parameter sets
module tb_pulse_gen_test;
    import pulse_gen_pkg::*;

    logic clk = 1'b0;
    logic nrst_a = 1'b0;
    logic nrst_b = 1'b0;
    logic nrst_c = 1'b0;

    always #5 clk = ~clk;

    pulse_gen_if if_a ();
    pulse_gen_if if_b ();
    pulse_gen_if if_c ();

    pulse_gen_test dut_a (
        .clk    (clk),
        .nrst   (nrst_a),
        .clkout (if_a.clkout)
    );

    pulse_gen_test #(.PERIOD(5), .WIDTH(2)) dut_b (
        .clk    (clk),
        .nrst   (nrst_b),
        .clkout (if_b.clkout)
    );

    pulse_gen_test #(.PERIOD(2), .WIDTH(1)) dut_c (
        .clk    (clk),
        .nrst   (nrst_c),
        .clkout (if_c.clkout)
    );

    typedef struct {
        logic nrst;
        logic exp;
    } vec_t;

    vec_t vecs [56];
    vec_t mid  [15];
    logic exp_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic dut_out(input int which);
        case (which)
            0:       return if_a.clkout;
            1:       return if_b.clkout;
            default: return if_c.clkout;
        endcase
    endfunction

    task automatic check_bit(input string name, input logic act, input logic want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, want);
        end
    endtask

    task automatic check_int(input string name, input int act, input int want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    // Drive one edge's inputs, queue the expected clkout, compare once the edge has happened.
    task automatic apply(input int which, input logic n, input logic e, input string name);
        logic want;
        case (which)
            0:       nrst_a = n;
            1:       nrst_b = n;
            default: nrst_c = n;
        endcase
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got empty scoreboard, expected one entry", name);
        end else begin
            want = exp_q.pop_front();
            check_bit(name, dut_out(which), want);
        end
    endtask

    initial begin
        int hi;
        int lo;
        int bad_cnt;
        int max_cnt;

        for (int i = 0; i < 6; i++) begin
            vecs[i] = '{1'b0, 1'b0};
        end
        for (int i = 6; i < 56; i++) begin
            vecs[i].nrst = 1'b1;
            vecs[i].exp  = (((i - 6) % PULSE_PERIOD_DEF) < PULSE_WIDTH_DEF);
        end

        mid = '{'{1'b1, 1'b0}, '{1'b1, 1'b0}, '{1'b1, 1'b1}, '{1'b1, 1'b0},
                '{1'b0, 1'b0}, '{1'b1, 1'b1}, '{1'b1, 1'b0}, '{1'b1, 1'b0},
                '{1'b1, 1'b0}, '{1'b1, 1'b1}, '{1'b1, 1'b0}, '{1'b1, 1'b0},
                '{1'b1, 1'b0}, '{1'b0, 1'b0}, '{1'b1, 1'b1}};

        hi = 0;
        for (int i = 0; i < 56; i++) begin
            apply(0, vecs[i].nrst, vecs[i].exp, $sformatf("a_vec%0d", i));
            if (vecs[i].nrst && if_a.clkout === 1'b1) hi++;
        end
        check_int("a_pulse_count", hi, 13);

        check_bit("b_reset", if_b.clkout, 1'b0);
        check_bit("c_reset", if_c.clkout, 1'b0);

        for (int i = 0; i < 15; i++) begin
            apply(0, mid[i].nrst, mid[i].exp, $sformatf("a_mid%0d", i));
        end

        hi = 0;
        lo = 0;
        bad_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            apply(1, 1'b1, (((k - 1) % 5) < 2), $sformatf("b_edge%0d", k));
            if (if_b.clkout === 1'b1) hi++;
            else lo++;
            if (int'(dut_b.cnt) >= 5) bad_cnt++;
        end
        check_int("b_high_count", hi, 8);
        check_int("b_low_count", lo, 12);
        check_int("b_cnt_range", bad_cnt, 0);

        max_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            apply(2, 1'b1, (k % 2 == 1), $sformatf("c_edge%0d", k));
            if (int'(dut_c.cnt) > max_cnt) max_cnt = int'(dut_c.cnt);
        end
        check_int("c_cnt_max", max_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
